// File: rtl/spi_peripheral.sv
// Write-only SPI mode-0 register file feeding the PWM block.
// All SPI pins are oversampled in the clk domain; sclk is never used as a clock.
module spi_peripheral #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclk,
   input  logic       copi,
   input  logic       ncs,
   output logic [7:0] en_reg_out_7_0,
   output logic [7:0] en_reg_out_15_8,
   output logic [7:0] en_reg_pwm_7_0,
   output logic [7:0] en_reg_pwm_15_8,
   output logic [7:0] pwm_duty_cycle
);

   localparam int unsigned CNT_W   = 5;
   localparam int unsigned SHIFT_W = 16;
   localparam int unsigned REG_W   = 8;
   localparam int unsigned ADDR_W  = 7;

   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(16);
   localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(17);
   localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(4);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
   logic [SYNC_STAGES-1:0] ncs_sync_q,  ncs_sync_d;
   logic [SYNC_STAGES:0]   vld_q,       vld_d;
   logic                   sclk_p_q,    sclk_p_d;
   logic                   ncs_p_q,     ncs_p_d;
   logic                   armed_q,     armed_d;

   logic [0:0]             state_q,     state_d;
   logic [CNT_W-1:0]       cnt_q,       cnt_d;
   logic [SHIFT_W-1:0]     shift_q,     shift_d;

   logic [REG_W-1:0]       out_lo_q,  out_lo_d;
   logic [REG_W-1:0]       out_hi_q,  out_hi_d;
   logic [REG_W-1:0]       pwm_lo_q,  pwm_lo_d;
   logic [REG_W-1:0]       pwm_hi_q,  pwm_hi_d;
   logic [REG_W-1:0]       duty_q,    duty_d;

   logic sclk_s, copi_s, ncs_s;
   logic sclk_rise_c, ncs_fall_c, ncs_rise_c, commit_c;
   logic [ADDR_W-1:0] addr_c;

   // Synchroniser chains plus previous-value flops for edge detection
   always_comb begin
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], copi};
      ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0],  ncs};
      vld_d       = {vld_q[SYNC_STAGES-1:0], 1'b1};
      sclk_s      = sclk_sync_q[SYNC_STAGES-1];
      copi_s      = copi_sync_q[SYNC_STAGES-1];
      ncs_s       = ncs_sync_q[SYNC_STAGES-1];
      sclk_p_d    = sclk_s;
      ncs_p_d     = ncs_s;
      // ncs must be seen high on real pin samples before a falling edge can start a frame
      armed_d     = armed_q | (vld_q[SYNC_STAGES] & ncs_s & ncs_p_q);
      sclk_rise_c = sclk_s & ~sclk_p_q;
      ncs_fall_c  = ~ncs_s & ncs_p_q & armed_q;
      ncs_rise_c  = ncs_s & ~ncs_p_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync_q <= '0;
         copi_sync_q <= '0;
         ncs_sync_q  <= '1;
         vld_q       <= '0;
         sclk_p_q    <= 1'b0;
         ncs_p_q     <= 1'b1;
         armed_q     <= 1'b0;
      end else begin
         sclk_sync_q <= sclk_sync_d;
         copi_sync_q <= copi_sync_d;
         ncs_sync_q  <= ncs_sync_d;
         vld_q       <= vld_d;
         sclk_p_q    <= sclk_p_d;
         ncs_p_q     <= ncs_p_d;
         armed_q     <= armed_d;
      end
   end

   // Frame FSM, shifter and register commit
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shift_d  = shift_q;
      out_lo_d = out_lo_q;
      out_hi_d = out_hi_q;
      pwm_lo_d = pwm_lo_q;
      pwm_hi_d = pwm_hi_q;
      duty_d   = duty_q;
      addr_c   = shift_q[14:8];
      commit_c = (state_q == ST_SHIFT) && ncs_rise_c && (cnt_q == CNT_FULL)
                 && shift_q[15] && (addr_c <= ADDR_MAX);

      case (state_q)
         ST_IDLE: begin
            if (ncs_fall_c) begin
               state_d = ST_SHIFT;
               cnt_d   = '0;
               shift_d = '0;
            end
         end
         ST_SHIFT: begin
            if (ncs_rise_c) begin
               state_d = ST_IDLE;
            end else if (sclk_rise_c) begin
               shift_d = {shift_q[SHIFT_W-2:0], copi_s};
               if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (commit_c) begin
         case (addr_c)
            ADDR_W'(0): out_lo_d = shift_q[7:0];
            ADDR_W'(1): out_hi_d = shift_q[7:0];
            ADDR_W'(2): pwm_lo_d = shift_q[7:0];
            ADDR_W'(3): pwm_hi_d = shift_q[7:0];
            ADDR_W'(4): duty_d   = shift_q[7:0];
            default:    ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         shift_q  <= '0;
         out_lo_q <= '0;
         out_hi_q <= '0;
         pwm_lo_q <= '0;
         pwm_hi_q <= '0;
         duty_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shift_q  <= shift_d;
         out_lo_q <= out_lo_d;
         out_hi_q <= out_hi_d;
         pwm_lo_q <= pwm_lo_d;
         pwm_hi_q <= pwm_hi_d;
         duty_q   <= duty_d;
      end
   end

   assign en_reg_out_7_0  = out_lo_q;
   assign en_reg_out_15_8 = out_hi_q;
   assign en_reg_pwm_7_0  = pwm_lo_q;
   assign en_reg_pwm_15_8 = pwm_hi_q;
   assign pwm_duty_cycle  = duty_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Bench for spi_peripheral: directed and random SPI frames against a register-level model.
module tb_spi_peripheral;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       sclk, copi, ncs;
   logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;

   int         chk_cnt  = 0;
   int         pass_cnt = 0;
   logic [7:0] exp_reg [5];
   logic [7:0] prev_reg [5];
   int         chg_cnt [5];

   spi_peripheral #(.SYNC_STAGES(2)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .sclk            (sclk),
      .copi            (copi),
      .ncs             (ncs),
      .en_reg_out_7_0  (en_reg_out_7_0),
      .en_reg_out_15_8 (en_reg_out_15_8),
      .en_reg_pwm_7_0  (en_reg_pwm_7_0),
      .en_reg_pwm_15_8 (en_reg_pwm_15_8),
      .pwm_duty_cycle  (pwm_duty_cycle)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] dut_reg(input int i);
      case (i)
         0:       return en_reg_out_7_0;
         1:       return en_reg_out_15_8;
         2:       return en_reg_pwm_7_0;
         3:       return en_reg_pwm_15_8;
         default: return pwm_duty_cycle;
      endcase
   endfunction

   // Reference: a frame writes only when exactly 16 bits, write bit set, address 0..4
   function automatic void model_frame(input logic [31:0] v, input int nbits);
      logic [6:0] a;
      a = v[14:8];
      if (nbits == 16 && v[15] == 1'b1 && a <= 7'd4) exp_reg[int'(a)] = v[7:0];
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 5; i++) exp_reg[i] = 8'h00;
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 5; i++) begin
         if (dut_reg(i) !== prev_reg[i]) chg_cnt[i]++;
         prev_reg[i] = dut_reg(i);
      end
   end

   task automatic send_frame(input logic [31:0] v, input int nbits, input int half, input int gap);
      ncs = 1'b0;
      repeat (3) @(negedge clk);
      for (int b = nbits - 1; b >= 0; b--) begin
         copi = v[b];
         sclk = 1'b0;
         repeat (half) @(negedge clk);
         sclk = 1'b1;
         repeat (half) @(negedge clk);
      end
      sclk = 1'b0;
      repeat (3) @(negedge clk);
      ncs = 1'b1;
      repeat (gap) @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (5) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk_cnt++;
         if (dut_reg(i) !== 8'h00) $display("FAIL reset_during reg%0d got=%h exp=00", i, dut_reg(i));
         else pass_cnt++;
      end
      rst_n = 1'b1;
      model_reset();
      repeat (5) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk_cnt++;
         if (dut_reg(i) !== 8'h00) $display("FAIL reset_after reg%0d got=%h exp=00", i, dut_reg(i));
         else pass_cnt++;
      end
   endtask

   task automatic test_basic();
      send_frame(32'h80F0, 16, 3, 0);
      model_frame(32'h80F0, 16);
      for (int e = 1; e <= 3; e++) begin
         @(posedge clk); #1;
         chk_cnt++;
         if (en_reg_out_7_0 !== (e == 3 ? 8'hF0 : 8'h00))
            $display("FAIL latency edge%0d got=%h exp=%h", e, en_reg_out_7_0, (e == 3 ? 8'hF0 : 8'h00));
         else pass_cnt++;
      end
      @(negedge clk);
      send_frame(32'h8480, 16, 4, 6);
      model_frame(32'h8480, 16);
      for (int i = 0; i < 5; i++) begin
         chk_cnt++;
         if (dut_reg(i) !== exp_reg[i]) $display("FAIL basic reg%0d got=%h exp=%h", i, dut_reg(i), exp_reg[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_invalid();
      logic [31:0] fr [5];
      int          nb [5];
      fr[0] = 32'h85AA;            nb[0] = 16;
      fr[1] = 32'h00FF;            nb[1] = 16;
      fr[2] = 32'h80FF >> 1;       nb[2] = 15;
      fr[3] = (32'h80FF << 1) | 1; nb[3] = 17;
      fr[4] = 32'h813C;            nb[4] = 16;
      // ncs glitch with no sclk activity
      ncs = 1'b0;
      repeat (4) @(negedge clk);
      ncs = 1'b1;
      repeat (6) @(negedge clk);
      for (int f = 0; f < 5; f++) begin
         send_frame(fr[f], nb[f], 3, 6);
         model_frame(fr[f], nb[f]);
         for (int i = 0; i < 5; i++) begin
            chk_cnt++;
            if (dut_reg(i) !== exp_reg[i])
               $display("FAIL invalid f%0d reg%0d got=%h exp=%h", f, i, dut_reg(i), exp_reg[i]);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_reset_midframe();
      logic [31:0] v = 32'h8255;
      ncs = 1'b0;
      repeat (3) @(negedge clk);
      for (int b = 15; b >= 8; b--) begin
         copi = v[b];
         sclk = 1'b0;
         repeat (3) @(negedge clk);
         sclk = 1'b1;
         repeat (3) @(negedge clk);
      end
      sclk = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (4) @(negedge clk);
      // ncs still low from before reset: clocking a full frame must not commit
      for (int b = 15; b >= 0; b--) begin
         copi = v[b];
         sclk = 1'b0;
         repeat (3) @(negedge clk);
         sclk = 1'b1;
         repeat (3) @(negedge clk);
      end
      sclk = 1'b0;
      repeat (3) @(negedge clk);
      ncs = 1'b1;
      repeat (6) @(negedge clk);
      chk_cnt++;
      if (en_reg_pwm_7_0 !== 8'h00) $display("FAIL midframe_hold got=%h exp=00", en_reg_pwm_7_0);
      else pass_cnt++;
      send_frame(v, 16, 3, 6);
      model_frame(v, 16);
      for (int i = 0; i < 5; i++) begin
         chk_cnt++;
         if (dut_reg(i) !== exp_reg[i]) $display("FAIL midframe reg%0d got=%h exp=%h", i, dut_reg(i), exp_reg[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 5; i++) chg_cnt[i] = 0;
      for (int a = 0; a < 5; a++) begin
         logic [31:0] v;
         v = 32'h8000 | (32'(a) << 8) | (32'(a + 1) * 32'h11);
         send_frame(v, 16, 3, 3);
         model_frame(v, 16);
      end
      repeat (6) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk_cnt++;
         if (dut_reg(i) !== exp_reg[i] || chg_cnt[i] != 1)
            $display("FAIL b2b reg%0d got=%h exp=%h changes=%0d exp_changes=1", i, dut_reg(i), exp_reg[i], chg_cnt[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 25; n++) begin
         logic [31:0] v;
         int          nbits;
         case ($urandom_range(0, 4))
            0:       nbits = 15;
            1:       nbits = 17;
            default: nbits = 16;
         endcase
         v = $urandom;
         v[15] = ($urandom_range(0, 3) != 0);
         v[14:8] = 7'($urandom_range(0, 7));
         send_frame(v, nbits, $urandom_range(3, 5), $urandom_range(3, 6));
         model_frame(v, nbits);
         repeat (4) @(negedge clk);
         for (int i = 0; i < 5; i++) begin
            chk_cnt++;
            if (dut_reg(i) !== exp_reg[i])
               $display("FAIL random n%0d reg%0d frame=%h bits=%0d got=%h exp=%h", n, i, v, nbits, dut_reg(i), exp_reg[i]);
            else pass_cnt++;
         end
      end
   endtask

   initial begin
      sclk  = 1'b0;
      copi  = 1'b0;
      ncs   = 1'b1;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         prev_reg[i] = 8'h00;
         chg_cnt[i]  = 0;
      end
      model_reset();
      @(negedge clk);
      test_reset();
      test_basic();
      test_invalid();
      test_reset_midframe();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
